counter_sched: RTL and testbench

Scheduler that shares one loadable W-bit up-counter among N requesters. Each requester posts a start value and a terminal value. The block arbitrates, loads the counter, counts up (with wrap) to the terminal value, then pulses completion back to the winner. It sits between the requesting control logic and the loadable counter datapath, and owns that counter's load/enable sequencing.

---
 rtl/cnt_sched_pkg.sv | 20 ++
 rtl/ld_cnt_core.sv | 33 +++
 rtl/counter_sched.sv | 157 +++++++++++++++
 tb/tb_counter_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cnt_sched_pkg
// Brief    : Shared types and defaults for the counter scheduler.
// Revision : 1.0
// ============================================================================
package cnt_sched_pkg;

    localparam int c_DEF_N = 2;
    localparam int c_DEF_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } cs_state_e;

endpackage
`default_nettype wire

// File: rtl/ld_cnt_core.sv
`default_nettype none
// ============================================================================
// Module   : ld_cnt_core
// Brief    : W-bit loadable up-counter; load beats enable, wraps mod 2^W.
// Revision : 1.0
// ============================================================================
module ld_cnt_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= data_in;
        end else if (enable) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched
// Brief    : Shares one loadable up-counter among N requesters.
//            Fixed lowest-index priority, or round-robin with CNT_SCHED_RR_EN.
// Revision : 1.0
// ============================================================================
module counter_sched
    import cnt_sched_pkg::*;
#(
    parameter int N = c_DEF_N,
    parameter int W = c_DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       start_val,
    input  logic [N*W-1:0]       end_val,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [W-1:0]         count,
    output logic                 done,
    output logic [$clog2(N)-1:0] done_id
);

    localparam int c_ID_W = $clog2(N);

    cs_state_e         state_q;
    logic [c_ID_W-1:0] owner_q;
    logic [W-1:0]      start_q;
    logic [W-1:0]      end_q;
    logic [N-1:0]      grant_q;
    logic              busy_q;
    logic              done_q;
    logic [c_ID_W-1:0] done_id_q;

    logic [c_ID_W-1:0] w_win;
    logic              w_own_req;
    logic              w_load;
    logic              w_enable;
    logic [W-1:0]      w_count;

`ifdef CNT_SCHED_RR_EN
    logic [c_ID_W-1:0] rr_ptr_q;
    int                w_idx;

    // Scan from the far end so the requester nearest the pointer is written last.
    always_comb begin
        w_win = '0;
        w_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(rr_ptr_q) + k) % N;
            if (req[c_ID_W'(w_idx)]) begin
                w_win = c_ID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (state_q == ST_IDLE && |req) begin
            rr_ptr_q <= (w_win == c_ID_W'(N - 1)) ? '0 : w_win + c_ID_W'(1);
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[c_ID_W'(k)]) begin
                w_win = c_ID_W'(k);
            end
        end
    end
`endif

    // Gating with the owner's request keeps the count frozen on the abort edge.
    assign w_own_req = req[owner_q];
    assign w_load    = (state_q == ST_LOAD) && w_own_req;
    assign w_enable  = (state_q == ST_COUNT) && w_own_req && (w_count != end_q);

    ld_cnt_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .enable  (w_enable),
        .data_in (start_q),
        .count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            start_q   <= '0;
            end_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        owner_q <= w_win;
                        start_q <= start_val[int'(w_win) * W +: W];
                        end_q   <= end_val[int'(w_win) * W +: W];
                        grant_q <= N'(1) << w_win;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!w_own_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!w_own_req) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (w_count == end_q) begin
                        done_q    <= 1'b1;
                        done_id_q <= owner_q;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign count   = w_count;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sched
// Brief    : Scoreboard bench for counter_sched with a job-timeline model.
// Revision : 1.0
// ============================================================================
module tb_counter_sched;

    localparam int N    = 2;
    localparam int W    = 4;
    localparam int IW   = $clog2(N);
    localparam int MASK = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] start_val = '0;
    logic [N*W-1:0] end_val = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic           done;
    logic [IW-1:0]  done_id;

    counter_sched #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .start_val (start_val),
        .end_val   (end_val),
        .grant     (grant),
        .busy      (busy),
        .count     (count),
        .done      (done),
        .done_id   (done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int endv;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Model: a granted job at edge k loads at k+1, finishes at k+2+D, frees at k+3+D.
    int m_own = -1;
    int m_k = 0, m_d = 0, m_start = 0, m_end = 0, m_ptr = 0, m_count = 0;
    bit m_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef CNT_SCHED_RR_EN
        for (int off = 0; off < N; off++) begin
            if (r[(p + off) % N]) return (p + off) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        int g;
        int el;
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            if (m_own >= 0 && cyc <= m_k + 2 + m_d && sb_q.size() > 0) void'(sb_q.pop_back());
            m_own   = -1;
            m_ptr   = 0;
            m_count = 0;
        end else if (m_own < 0) begin
            if (req != '0) begin
                g       = pick(req, m_ptr);
                m_own   = g;
                m_k     = cyc;
                m_start = int'(start_val[g*W +: W]);
                m_end   = int'(end_val[g*W +: W]);
                m_d     = (m_end - m_start) & MASK;
                m_ptr   = (g + 1) % N;
                sb_q.push_back('{id: g, endv: m_end, cyc: cyc + 2 + m_d});
            end
        end else if (cyc == m_k + 3 + m_d) begin
            m_own = -1;
        end else if (!req[m_own]) begin
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            m_own = -1;
        end else begin
            el      = cyc - m_k - 1;
            m_count = (m_start + ((el < m_d) ? el : m_d)) & MASK;
            m_done  = (cyc == m_k + 2 + m_d);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("grant", grant, (m_own >= 0) ? (1 << m_own) : 0);
        chk("busy", busy, (m_own >= 0) ? 1 : 0);
        chk("count", count, m_count);
        chk("done", done, m_done);
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard at cycle %0d: done with id %0d but no job expected", cyc, done_id);
            end else begin
                e = sb_q.pop_front();
                chk("done_id", done_id, e.id);
                chk("done_count", count, e.endv);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_job(input int i, input int s, input int e);
        start_val[i*W +: W] = W'(s);
        end_val[i*W +: W]   = W'(e);
        req[i]              = 1'b1;
    endtask

    task automatic wait_done(input int i);
        bit hit = 1'b0;
        for (int t = 0; t < 80 && !hit; t++) begin
            @(negedge clk);
            if (done === 1'b1 && done_id == IW'(i)) hit = 1'b1;
        end
        req[i] = 1'b0;
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_done timeout for requester %0d: got no done, expected done", i);
        end
    endtask

    task automatic wait_count(input int i, input int v);
        bit hit = 1'b0;
        for (int t = 0; t < 80 && !hit; t++) begin
            @(negedge clk);
            if (grant[i] === 1'b1 && count == W'(v)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_count timeout requester %0d: got count %0d, expected %0d", i, count, v);
        end
    endtask

    initial begin
        int jl[N];
        @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        set_job(0, 5, 9);
        wait_done(0);
        repeat (2) @(negedge clk);

        set_job(1, 14, 2);
        wait_done(1);
        repeat (2) @(negedge clk);

        set_job(0, 3, 12);
        wait_count(0, 7);
        rst    = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        set_job(0, 0, 10);
        set_job(1, 6, 8);
        wait_count(0, 4);
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_count", count, 4);
        wait_done(1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++) begin
            jl[i] = 2;
            start_val[i*W +: W] = W'(i * 3);
            end_val[i*W +: W]   = W'(i * 3 + 2);
        end
        req = '1;
        for (int t = 0; t < 300 && (jl[0] + jl[1] > 0 || req != '0); t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                req[done_id] = 1'b0;
                jl[done_id]--;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && jl[i] > 0) req[i] = 1'b1;
                end
            end
        end
        chk("contention_jobs_left", jl[0] + jl[1], 0);
        req = '0;
        repeat (3) @(negedge clk);

        repeat (1500) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            start_val = (N*W)'($urandom);
            end_val   = (N*W)'($urandom);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (done === 1'b1 && done_id == IW'(i)) req[i] = 1'b0;
                    else if ($urandom_range(0, 59) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
        end

        rst = 1'b0;
        req = '0;
        repeat (40) @(negedge clk);
        chk("scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
